// File: rtl/sha256_pkg.sv
// Shared types and helpers for the SHA-256 message padder.
// SHA_PADDER_BYTE_LEN_EN switches message lengths from words to bytes.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RD,
        ST_WT,
        ST_CAP,
        ST_WR,
        ST_PAD,
        ST_DONE
    } pad_state_e;

    localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

    // Padded size in 512-bit blocks; wide enough that oversize lengths never alias.
    function automatic logic [16:0] blocks_for_len(input logic [15:0] len);
        logic [31:0] tmp;
`ifdef SHA_PADDER_BYTE_LEN_EN
        tmp = ({16'd0, len} + 32'd8) / 32'd64 + 32'd1;
`else
        tmp = ({16'd0, len} + 32'd18) / 32'd16;
`endif
        return tmp[16:0];
    endfunction

`ifdef SHA_PADDER_BYTE_LEN_EN
    function automatic logic [31:0] last_word_mask(input logic [1:0] nbytes);
        logic [31:0] mask;
        case (nbytes)
            2'd1:    mask = 32'hFF00_0000;
            2'd2:    mask = 32'hFFFF_0000;
            2'd3:    mask = 32'hFFFF_FF00;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction
`endif

endpackage

// File: rtl/sha256_msg_padder.sv
// Copies a raw message into a padded region of whole 512-bit blocks for the SHA-256 hasher.
// Define SHA_PADDER_BYTE_LEN_EN for byte-granular message lengths.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int MAX_BLOCKS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] msg_addr,
    input  logic [15:0] msg_len,
    input  logic [15:0] pad_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  num_blocks,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    pad_state_e  state_q, state_d;
    logic [15:0] msg_addr_q, msg_addr_d;
    logic [15:0] len_q, len_d;
    logic [15:0] pad_addr_q, pad_addr_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  blocks_q, blocks_d;
    logic [31:0] cap_q, cap_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  num_blocks_q, num_blocks_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [15:0] nwords;
    logic [15:0] last_idx;
    logic [16:0] b_full;
    logic        too_long;
    logic [63:0] bit_len;
    logic [31:0] wr_word;
    logic [31:0] pad_word;

    assign mem_clk = clk;

`ifdef SHA_PADDER_BYTE_LEN_EN
    logic [16:0] nwords_wide;
    assign nwords_wide = ({1'b0, len_q} + 17'd3) >> 2;
    assign nwords      = nwords_wide[15:0];
    assign bit_len     = {45'd0, len_q, 3'd0};
`else
    assign nwords      = len_q;
    assign bit_len     = {43'd0, len_q, 5'd0};
`endif

    assign last_idx = {4'd0, blocks_q, 4'd0} - 16'd1;
    assign b_full   = blocks_for_len(len_q);
    assign too_long = b_full > 17'(MAX_BLOCKS);

    always_comb begin
        wr_word = cap_q;
`ifdef SHA_PADDER_BYTE_LEN_EN
        // A partial final word is trimmed and carries the marker byte itself.
        if ((idx_q == nwords - 16'd1) && (len_q[1:0] != 2'd0)) begin
            wr_word = (cap_q & last_word_mask(len_q[1:0]))
                    | (PAD_MARKER >> {len_q[1:0], 3'd0});
        end
`endif
    end

    always_comb begin
        pad_word = 32'd0;
        if (idx_q == last_idx - 16'd1) begin
            pad_word = bit_len[63:32];
        end else if (idx_q == last_idx) begin
            pad_word = bit_len[31:0];
        end else if (idx_q == nwords) begin
`ifdef SHA_PADDER_BYTE_LEN_EN
            pad_word = (len_q[1:0] == 2'd0) ? PAD_MARKER : 32'd0;
`else
            pad_word = PAD_MARKER;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        msg_addr_d   = msg_addr_q;
        len_d        = len_q;
        pad_addr_d   = pad_addr_q;
        idx_d        = idx_q;
        blocks_d     = blocks_q;
        cap_d        = cap_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        num_blocks_d = 8'd0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    msg_addr_d = msg_addr;
                    len_d      = msg_len;
                    pad_addr_d = pad_addr;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                idx_d    = 16'd0;
                blocks_d = b_full[7:0];
                if (too_long) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = (nwords == 16'd0) ? ST_PAD : ST_RD;
                end
            end
            ST_RD: begin
                busy_d     = 1'b1;
                mem_addr_d = msg_addr_q + idx_q;
                state_d    = ST_WT;
            end
            ST_WT: begin
                busy_d  = 1'b1;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                busy_d  = 1'b1;
                cap_d   = mem_read_data;
                state_d = ST_WR;
            end
            ST_WR: begin
                busy_d      = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = pad_addr_q + idx_q;
                mem_wdata_d = wr_word;
                idx_d       = idx_q + 16'd1;
                state_d     = (idx_q + 16'd1 == nwords) ? ST_PAD : ST_RD;
            end
            ST_PAD: begin
                busy_d      = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = pad_addr_q + idx_q;
                mem_wdata_d = pad_word;
                idx_d       = idx_q + 16'd1;
                if (idx_q == last_idx) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    msg_addr_d = msg_addr;
                    len_d      = msg_len;
                    pad_addr_d = pad_addr;
                    state_d    = ST_SETUP;
                end else begin
                    done_d       = 1'b1;
                    err_d        = err_q;
                    num_blocks_d = blocks_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the current state, so done trails the last write by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            msg_addr_q   <= 16'd0;
            len_q        <= 16'd0;
            pad_addr_q   <= 16'd0;
            idx_q        <= 16'd0;
            blocks_q     <= 8'd0;
            cap_q        <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            num_blocks_q <= 8'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            msg_addr_q   <= msg_addr_d;
            len_q        <= len_d;
            pad_addr_q   <= pad_addr_d;
            idx_q        <= idx_d;
            blocks_q     <= blocks_d;
            cap_q        <= cap_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            num_blocks_q <= num_blocks_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign num_blocks     = num_blocks_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder with a two-cycle-latency memory model.
// Build with SHA_PADDER_BYTE_LEN_EN defined to run the byte-length vectors instead.
module tb_sha256_msg_padder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] msg_addr;
    logic [15:0] msg_len;
    logic [15:0] pad_addr;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  num_blocks;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:65535];
    logic [31:0] rd_pipe;
    logic        tb_we;
    logic [15:0] tb_addr;
    logic [31:0] tb_data;
    int          we_count;

    int vectors;
    int miscompares;

    sha256_msg_padder #(.MAX_BLOCKS(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .msg_addr       (msg_addr),
        .msg_len        (msg_len),
        .pad_addr       (pad_addr),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .num_blocks     (num_blocks),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address registered at edge N is visible after edge N+1 and captured by the DUT at N+2.
    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_write_data;
        end
        rd_pipe <= mem[mem_addr];
    end
    assign mem_read_data = rd_pipe;

    initial we_count = 0;
    always @(posedge clk) begin
        if (mem_we) we_count <= we_count + 1;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic memLoad(input logic [15:0] addr, input logic [31:0] data);
        tb_addr = addr;
        tb_data = data;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    task automatic fillRegion(input logic [15:0] base, input int count);
        for (int k = 0; k < count; k++) begin
            memLoad(base + 16'(k), 32'hDEAD_BEEF);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_nblk"}, num_blocks, 0);
        checkOutput({tag, "_we"}, mem_we, 0);
        checkOutput({tag, "_addr"}, mem_addr, 0);
        checkOutput({tag, "_wdata"}, mem_write_data, 0);
    endtask

    // Runs one job; cycles counts clock edges from the edge that samples start to done.
    task automatic applyStimulus(input logic [15:0] maddr, input logic [15:0] len,
                                 input logic [15:0] paddr, input bit poke,
                                 output int cycles, output int writes);
        int we_start;
        @(negedge clk);
        msg_addr = maddr;
        msg_len  = len;
        pad_addr = paddr;
        start    = 1'b1;
        @(posedge clk);
        we_start = we_count;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_clear", done, 0);
        cycles = 0;
        while (!done && cycles < 2000) begin
            if (poke && cycles == 5) begin
                start    = 1'b1;
                msg_len  = 16'd1;
                pad_addr = 16'h0000;
            end else if (poke && cycles == 6) begin
                start = 1'b0;
            end
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        writes = we_count - we_start;
        checkOutput("done_seen", done, 1);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("we_at_done", mem_we, 0);
    endtask

    int cyc;
    int wr;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        msg_addr    = 16'd0;
        msg_len     = 16'd0;
        pad_addr    = 16'd0;
        tb_we       = 1'b0;
        tb_addr     = 16'd0;
        tb_data     = 32'd0;

        @(negedge clk);
        checkResetOutputs("reset");

`ifdef SHA_PADDER_BYTE_LEN_EN
        memLoad(16'h0040, 32'h0102_0304);
        memLoad(16'h0041, 32'hAABB_CCDD);
        fillRegion(16'h0100, 17);
        fillRegion(16'h0200, 17);
        fillRegion(16'h0300, 17);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(16'h0040, 16'd5, 16'h0100, 1'b0, cyc, wr);
        checkOutput("b5_cycles", cyc, 24);
        checkOutput("b5_nblk", num_blocks, 1);
        checkOutput("b5_err", err, 0);
        checkOutput("b5_w0", mem[16'h0100], 32'h0102_0304);
        checkOutput("b5_w1", mem[16'h0101], 32'hAA80_0000);
        checkOutput("b5_w2", mem[16'h0102], 32'h0000_0000);
        checkOutput("b5_w15", mem[16'h010F], 32'h0000_0028);
        checkOutput("b5_after", mem[16'h0110], 32'hDEAD_BEEF);

        applyStimulus(16'h0040, 16'd4, 16'h0200, 1'b0, cyc, wr);
        checkOutput("b4_cycles", cyc, 21);
        checkOutput("b4_w0", mem[16'h0200], 32'h0102_0304);
        checkOutput("b4_w1", mem[16'h0201], 32'h8000_0000);
        checkOutput("b4_w15", mem[16'h020F], 32'h0000_0020);

        applyStimulus(16'h0040, 16'd7, 16'h0300, 1'b0, cyc, wr);
        checkOutput("b7_w1", mem[16'h0301], 32'hAABB_CC80);
        checkOutput("b7_w2", mem[16'h0302], 32'h0000_0000);
        checkOutput("b7_w15", mem[16'h030F], 32'h0000_0038);

        applyStimulus(16'h0040, 16'd250, 16'h0300, 1'b0, cyc, wr);
        checkOutput("b250_cycles", cyc, 2);
        checkOutput("b250_err", err, 1);
        checkOutput("b250_writes", wr, 0);
`else
        for (int k = 0; k < 20; k++) begin
            memLoad(16'h0040 + 16'(k), 32'h1111_1111 * (k + 1));
        end
        fillRegion(16'h0100, 32);
        fillRegion(16'h0200, 17);
        fillRegion(16'h0300, 32);
        fillRegion(16'h0400, 32);
        fillRegion(16'hFFF8, 8);
        fillRegion(16'h0000, 8);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(16'h0040, 16'd20, 16'h0100, 1'b0, cyc, wr);
        checkOutput("w20_cycles", cyc, 94);
        checkOutput("w20_nblk", num_blocks, 2);
        checkOutput("w20_err", err, 0);
        checkOutput("w20_writes", wr, 32);
        checkOutput("w20_m0", mem[16'h0100], 32'h1111_1111);
        checkOutput("w20_m19", mem[16'h0113], 32'h5555_5554);
        checkOutput("w20_marker", mem[16'h0114], 32'h8000_0000);
        checkOutput("w20_zero", mem[16'h0118], 32'h0000_0000);
        checkOutput("w20_lenhi", mem[16'h011E], 32'h0000_0000);
        checkOutput("w20_lenlo", mem[16'h011F], 32'h0000_0280);

        applyStimulus(16'h0040, 16'd0, 16'h0200, 1'b0, cyc, wr);
        checkOutput("w0_cycles", cyc, 18);
        checkOutput("w0_nblk", num_blocks, 1);
        checkOutput("w0_err", err, 0);
        checkOutput("w0_marker", mem[16'h0200], 32'h8000_0000);
        checkOutput("w0_zero", mem[16'h0201], 32'h0000_0000);
        checkOutput("w0_w15", mem[16'h020F], 32'h0000_0000);
        checkOutput("w0_after", mem[16'h0210], 32'hDEAD_BEEF);

        applyStimulus(16'h0040, 16'd14, 16'h0300, 1'b1, cyc, wr);
        checkOutput("w14_cycles", cyc, 76);
        checkOutput("w14_nblk", num_blocks, 2);
        checkOutput("w14_m13", mem[16'h030D], 32'hEEEE_EEEE);
        checkOutput("w14_marker", mem[16'h030E], 32'h8000_0000);
        checkOutput("w14_zero", mem[16'h030F], 32'h0000_0000);
        checkOutput("w14_lenhi", mem[16'h031E], 32'h0000_0000);
        checkOutput("w14_lenlo", mem[16'h031F], 32'h0000_01C0);

        applyStimulus(16'h0040, 16'd62, 16'h0100, 1'b0, cyc, wr);
        checkOutput("w62_cycles", cyc, 2);
        checkOutput("w62_err", err, 1);
        checkOutput("w62_nblk", num_blocks, 5);
        checkOutput("w62_writes", wr, 0);

        applyStimulus(16'h0040, 16'd2, 16'hFFF8, 1'b0, cyc, wr);
        checkOutput("wrap_cycles", cyc, 24);
        checkOutput("wrap_err", err, 0);
        checkOutput("wrap_nblk", num_blocks, 1);
        checkOutput("wrap_m0", mem[16'hFFF8], 32'h1111_1111);
        checkOutput("wrap_m1", mem[16'hFFF9], 32'h2222_2222);
        checkOutput("wrap_marker", mem[16'hFFFA], 32'h8000_0000);
        checkOutput("wrap_w14", mem[16'h0006], 32'h0000_0000);
        checkOutput("wrap_w15", mem[16'h0007], 32'h0000_0040);

        @(negedge clk);
        msg_addr = 16'h0040;
        msg_len  = 16'd20;
        pad_addr = 16'h0400;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        checkResetOutputs("abort");
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput("abort_m2", mem[16'h0402], 32'h3333_3333);
        checkOutput("abort_m3", mem[16'h0403], 32'hDEAD_BEEF);

        applyStimulus(16'h0040, 16'd20, 16'h0400, 1'b0, cyc, wr);
        checkOutput("rerun_cycles", cyc, 94);
        checkOutput("rerun_nblk", num_blocks, 2);
        checkOutput("rerun_m3", mem[16'h0403], 32'h4444_4444);
        checkOutput("rerun_marker", mem[16'h0414], 32'h8000_0000);
        checkOutput("rerun_lenlo", mem[16'h041F], 32'h0000_0280);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
